// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, data port and the shared memory port.
// The slave modport is the arbiter's view (it answers the requesters and drives memory).
// The master modport is the environment's view (requesters plus memory model).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // fetch side
  logic                  inst_req;
  logic [ADDR_W-1:0]     inst_addr;
  logic                  inst_gnt;
  logic                  inst_flush;
  logic [DATA_W-1:0]     inst_rdata;
  logic                  inst_rvalid;
  // data side
  logic                  data_req;
  logic                  data_wr;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W-1:0]     data_wdata;
  logic [DATA_W/8-1:0]   data_wstrb;
  logic                  data_gnt;
  logic [DATA_W-1:0]     data_rdata;
  logic                  data_rvalid;
  // memory side
  logic                  mem_req;
  logic                  mem_wr;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic                  mem_addr_ok;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_data_ok;

  modport slave (
    input  inst_req, inst_addr, inst_flush,
    output inst_gnt, inst_rdata, inst_rvalid,
    input  data_req, data_wr, data_addr, data_wdata, data_wstrb,
    output data_gnt, data_rdata, data_rvalid,
    output mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_addr_ok, mem_rdata, mem_data_ok
  );

  modport master (
    output inst_req, inst_addr, inst_flush,
    input  inst_gnt, inst_rdata, inst_rvalid,
    output data_req, data_wr, data_addr, data_wdata, data_wstrb,
    input  data_gnt, data_rdata, data_rvalid,
    input  mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb,
    output mem_addr_ok, mem_rdata, mem_data_ok
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one in-order pipelined memory port between instruction fetch
// and the data stage. One grant per cycle, outstanding requests tracked in an ID FIFO of
// {src, killed} entries, in-order responses routed back to their owner. Fetch responses
// whose request was killed by inst_flush are dropped.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration on contested
// cycles; otherwise data has fixed priority over fetch.
// Grants and response valids are combinational (zero-latency handshake on both sides).

// Protocol checks kept apart from the datapath.
module mem_port_arbiter_chk (
  input logic clk,
  input logic reset,
  input logic mem_data_ok,
  input logic fifo_empty,
  input logic inst_gnt,
  input logic data_gnt
);
  a_resp_needs_outstanding: assert property (@(posedge clk) disable iff (reset)
    !(mem_data_ok && fifo_empty));
  a_single_grant: assert property (@(posedge clk) disable iff (reset)
    !(inst_gnt && data_gnt));
endmodule

module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  // ID FIFO storage: one src bit and one killed bit per slot
  logic [MAX_OUTSTANDING-1:0] src_q, src_d;
  logic [MAX_OUTSTANDING-1:0] killed_q, killed_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  logic inst_vld_s;
  logic data_vld_s;
  logic pick_data_s;
  logic fifo_empty_s;
  logic fifo_full_s;
  logic pop_s;
  logic push_s;
  logic mem_req_s;
  logic head_src_s;
  logic head_killed_s;
  logic inst_rvalid_s;
  logic data_rvalid_s;

  // Request qualification, FIFO occupancy and handshake decode
  always_comb begin
    // a fetch is never eligible in a flush cycle
    inst_vld_s    = bus.inst_req & ~bus.inst_flush;
    data_vld_s    = bus.data_req;
    fifo_empty_s  = (cnt_q == CNT_ZERO);
    pop_s         = bus.mem_data_ok & ~fifo_empty_s & ~reset;
    // a pop in the same cycle frees a slot, so a full FIFO can still accept a push
    fifo_full_s   = (cnt_q == CNT_FULL) & ~pop_s;
    mem_req_s     = (inst_vld_s | data_vld_s) & ~fifo_full_s & ~reset;
    push_s        = mem_req_s & bus.mem_addr_ok;
    head_src_s    = src_q[rd_ptr_q];
    head_killed_s = killed_q[rd_ptr_q];
  end

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [0:0] RR_INST = 1'b0;
  localparam logic [0:0] RR_DATA = 1'b1;

  logic [0:0] rr_q, rr_d;

  // Winner select: the favoured source wins a contested cycle; pointer moves to the loser
  always_comb begin
    if (data_vld_s && inst_vld_s) begin
      pick_data_s = (rr_q == RR_DATA);
    end else begin
      pick_data_s = data_vld_s;
    end
    if (push_s && data_vld_s && inst_vld_s) begin
      if (pick_data_s) begin
        rr_d = RR_INST;
      end else begin
        rr_d = RR_DATA;
      end
    end else begin
      rr_d = rr_q;
    end
  end

  // Round-robin pointer register, data favoured out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= RR_DATA;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  // Winner select: fixed priority, data over fetch
  always_comb begin
    pick_data_s = data_vld_s;
  end
`endif

  // FIFO next state: flush marking, push of the granted source, pop of the head
  always_comb begin
    src_d    = src_q;
    killed_d = killed_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (bus.inst_flush && (src_q[i] == SRC_INST)) begin
        killed_d[i] = 1'b1;
      end else begin
        killed_d[i] = killed_q[i];
      end
    end
    if (push_s) begin
      src_d[wr_ptr_q]    = pick_data_s ? SRC_DATA : SRC_INST;
      killed_d[wr_ptr_q] = ~pick_data_s & bus.inst_flush;
      wr_ptr_d           = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers; reset drops all outstanding tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q    <= {MAX_OUTSTANDING{1'b0}};
      killed_q <= {MAX_OUTSTANDING{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= CNT_ZERO;
    end else begin
      src_q    <= src_d;
      killed_q <= killed_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Response routing: head owner gets the valid unless the entry was killed
  always_comb begin
    inst_rvalid_s = pop_s & (head_src_s == SRC_INST) & ~head_killed_s & ~bus.inst_flush;
    data_rvalid_s = pop_s & (head_src_s == SRC_DATA);
  end

  // Output drive: memory payload from the winner, grants and routed responses
  always_comb begin
    bus.mem_req   = mem_req_s;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    bus.mem_wstrb = {(DATA_W/8){1'b0}};
    if (mem_req_s) begin
      if (pick_data_s) begin
        bus.mem_wr    = bus.data_wr;
        bus.mem_addr  = bus.data_addr;
        bus.mem_wdata = bus.data_wdata;
        bus.mem_wstrb = bus.data_wr ? bus.data_wstrb : {(DATA_W/8){1'b0}};
      end else begin
        bus.mem_addr  = bus.inst_addr;
      end
    end else begin
      bus.mem_addr  = {ADDR_W{1'b0}};
    end
    bus.inst_gnt    = push_s & ~pick_data_s;
    bus.data_gnt    = push_s & pick_data_s;
    bus.inst_rvalid = inst_rvalid_s;
    bus.data_rvalid = data_rvalid_s;
    bus.inst_rdata  = inst_rvalid_s ? bus.mem_rdata : {DATA_W{1'b0}};
    bus.data_rdata  = data_rvalid_s ? bus.mem_rdata : {DATA_W{1'b0}};
  end

  mem_port_arbiter_chk u_chk (
    .clk         (clk),
    .reset       (reset),
    .mem_data_ok (bus.mem_data_ok),
    .fifo_empty  (fifo_empty_s),
    .inst_gnt    (bus.inst_gnt),
    .data_gnt    (bus.data_gnt)
  );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs change 1 time unit after the rising edge,
// outputs are sampled 1 time unit later. The arbitration test follows ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.inst_req    = 1'b0;
    bus.inst_addr   = 32'h0;
    bus.inst_flush  = 1'b0;
    bus.data_req    = 1'b0;
    bus.data_wr     = 1'b0;
    bus.data_addr   = 32'h0;
    bus.data_wdata  = 32'h0;
    bus.data_wstrb  = 4'h0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_rdata   = 32'h0;
    bus.mem_data_ok = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    idle();
    tick();
    // requests during reset must not be granted
    bus.inst_req    = 1'b1;
    bus.inst_addr   = 32'h1234_5678;
    bus.mem_addr_ok = 1'b1;
    #1;
    chk("rst_mem_req",  {31'd0, bus.mem_req},  32'd0);
    chk("rst_inst_gnt", {31'd0, bus.inst_gnt}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr,          32'h0);
    tick();
    reset = 1'b0;
    idle();
    tick();

    // 1: single fetch, response next cycle
    bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC0_0000; bus.mem_addr_ok = 1'b1;
    #1;
    chk("t1_mem_req",  {31'd0, bus.mem_req},  32'd1);
    chk("t1_inst_gnt", {31'd0, bus.inst_gnt}, 32'd1);
    chk("t1_data_gnt", {31'd0, bus.data_gnt}, 32'd0);
    chk("t1_mem_addr", bus.mem_addr,          32'hBFC0_0000);
    chk("t1_mem_wr",   {31'd0, bus.mem_wr},   32'd0);
    chk("t1_mem_wstrb",{28'd0, bus.mem_wstrb},32'd0);
    tick();
    idle(); bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h1111_2222;
    #1;
    chk("t1_inst_rvalid", {31'd0, bus.inst_rvalid}, 32'd1);
    chk("t1_inst_rdata",  bus.inst_rdata,           32'h1111_2222);
    chk("t1_data_rvalid", {31'd0, bus.data_rvalid}, 32'd0);
    tick();
    idle();
    #1;
    chk("t1_idle_rvalid", {31'd0, bus.inst_rvalid}, 32'd0);
    tick();

    // 2: both request in one cycle; data first, then fetch
    bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_1000;
    bus.data_req = 1'b1; bus.data_addr = 32'h0000_2000; bus.mem_addr_ok = 1'b1;
    #1;
    chk("t2_c0_data_gnt", {31'd0, bus.data_gnt}, 32'd1);
    chk("t2_c0_inst_gnt", {31'd0, bus.inst_gnt}, 32'd0);
    chk("t2_c0_mem_addr", bus.mem_addr,          32'h0000_2000);
    tick();
    bus.data_req = 1'b0;
    #1;
    chk("t2_c1_inst_gnt", {31'd0, bus.inst_gnt}, 32'd1);
    chk("t2_c1_mem_addr", bus.mem_addr,          32'h0000_1000);
    tick();
    idle(); bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'hAAAA_0001;
    #1;
    chk("t2_r0_data_rvalid", {31'd0, bus.data_rvalid}, 32'd1);
    chk("t2_r0_inst_rvalid", {31'd0, bus.inst_rvalid}, 32'd0);
    chk("t2_r0_data_rdata",  bus.data_rdata,           32'hAAAA_0001);
    tick();
    bus.mem_rdata = 32'hAAAA_0002;
    #1;
    chk("t2_r1_inst_rvalid", {31'd0, bus.inst_rvalid}, 32'd1);
    chk("t2_r1_data_rvalid", {31'd0, bus.data_rvalid}, 32'd0);
    chk("t2_r1_inst_rdata",  bus.inst_rdata,           32'hAAAA_0002);
    tick();
    idle();
    tick();

    // 3: fill the FIFO with four fetches, then stall, then push and pop together
    for (int i = 0; i < 4; i++) begin
      bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_3000 + 32'(4 * i); bus.mem_addr_ok = 1'b1;
      #1;
      chk("t3_fill_gnt", {31'd0, bus.inst_gnt}, 32'd1);
      tick();
    end
    bus.inst_addr = 32'h0000_3010;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t3_full_mem_req", {31'd0, bus.mem_req},  32'd0);
      chk("t3_full_gnt",     {31'd0, bus.inst_gnt}, 32'd0);
      tick();
    end
    bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h3000_0000;
    #1;
    chk("t3_pp_rvalid",   {31'd0, bus.inst_rvalid}, 32'd1);
    chk("t3_pp_rdata",    bus.inst_rdata,           32'h3000_0000);
    chk("t3_pp_mem_req",  {31'd0, bus.mem_req},     32'd1);
    chk("t3_pp_gnt",      {31'd0, bus.inst_gnt},    32'd1);
    chk("t3_pp_mem_addr", bus.mem_addr,             32'h0000_3010);
    tick();
    bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0;
    for (int i = 1; i < 5; i++) begin
      bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h3000_0000 + 32'(i);
      #1;
      chk("t3_drain_rvalid", {31'd0, bus.inst_rvalid}, 32'd1);
      chk("t3_drain_rdata",  bus.inst_rdata,           32'h3000_0000 + 32'(i));
      tick();
    end
    idle();
    tick();

    // 4: flush kills outstanding fetches
    bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_4000; bus.mem_addr_ok = 1'b1;
    #1;
    chk("t4_f0_gnt", {31'd0, bus.inst_gnt}, 32'd1);
    tick();
    bus.inst_addr = 32'h0000_4004;
    #1;
    chk("t4_f1_gnt", {31'd0, bus.inst_gnt}, 32'd1);
    tick();
    bus.inst_flush = 1'b1; bus.inst_addr = 32'h0000_4008;
    #1;
    chk("t4_flush_gnt",     {31'd0, bus.inst_gnt}, 32'd0);
    chk("t4_flush_mem_req", {31'd0, bus.mem_req},  32'd0);
    tick();
    idle();
    for (int i = 0; i < 2; i++) begin
      bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h4444_0000 + 32'(i);
      #1;
      chk("t4_killed_inst_rvalid", {31'd0, bus.inst_rvalid}, 32'd0);
      chk("t4_killed_data_rvalid", {31'd0, bus.data_rvalid}, 32'd0);
      tick();
    end
    idle();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_4008; bus.mem_addr_ok = 1'b1;
    #1;
    chk("t4_after_gnt", {31'd0, bus.inst_gnt}, 32'd1);
    tick();
    idle(); bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h4444_0008;
    #1;
    chk("t4_after_rvalid", {31'd0, bus.inst_rvalid}, 32'd1);
    chk("t4_after_rdata",  bus.inst_rdata,           32'h4444_0008);
    tick();
    // fetch whose response arrives in a flush cycle; data still granted in that cycle
    idle(); bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_400C; bus.mem_addr_ok = 1'b1;
    #1;
    chk("t4_late_gnt", {31'd0, bus.inst_gnt}, 32'd1);
    tick();
    idle();
    bus.inst_flush = 1'b1; bus.data_req = 1'b1; bus.data_addr = 32'h0000_5000;
    bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h4444_000C;
    #1;
    chk("t4_popflush_rvalid", {31'd0, bus.inst_rvalid}, 32'd0);
    chk("t4_popflush_dgnt",   {31'd0, bus.data_gnt},    32'd1);
    tick();
    idle(); bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h5555_0000;
    #1;
    chk("t4_load_rvalid", {31'd0, bus.data_rvalid}, 32'd1);
    chk("t4_load_rdata",  bus.data_rdata,           32'h5555_0000);
    tick();
    idle();
    tick();

    // 5: store, first stalled by mem_addr_ok=0
    bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_addr = 32'h8000_0010;
    bus.data_wdata = 32'hDEAD_BEEF; bus.data_wstrb = 4'hF; bus.mem_addr_ok = 1'b0;
    #1;
    chk("t5_stall_mem_req", {31'd0, bus.mem_req},  32'd1);
    chk("t5_stall_gnt",     {31'd0, bus.data_gnt}, 32'd0);
    tick();
    bus.mem_addr_ok = 1'b1;
    #1;
    chk("t5_gnt",       {31'd0, bus.data_gnt}, 32'd1);
    chk("t5_mem_wr",    {31'd0, bus.mem_wr},   32'd1);
    chk("t5_mem_addr",  bus.mem_addr,          32'h8000_0010);
    chk("t5_mem_wdata", bus.mem_wdata,         32'hDEAD_BEEF);
    chk("t5_mem_wstrb", {28'd0, bus.mem_wstrb},32'h0000_000F);
    tick();
    idle(); bus.mem_data_ok = 1'b1;
    #1;
    chk("t5_ack_rvalid", {31'd0, bus.data_rvalid}, 32'd1);
    chk("t5_ack_inst",   {31'd0, bus.inst_rvalid}, 32'd0);
    tick();
    idle();

    // 6: both held high; reset first so the arbiter starts from its reset state
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.inst_req = 1'b1; bus.inst_addr = 32'h0000_6000;
    bus.data_req = 1'b1; bus.data_addr = 32'h0000_7000; bus.mem_addr_ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.mem_data_ok = (k > 0) ? 1'b1 : 1'b0;
      #1;
`ifdef ARB_ROUND_ROBIN_EN
      chk("t6_rr_data_gnt", {31'd0, bus.data_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("t6_rr_inst_gnt", {31'd0, bus.inst_gnt}, (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k > 0) begin
        chk("t6_rr_route_d", {31'd0, bus.data_rvalid}, (k % 2 == 1) ? 32'd1 : 32'd0);
        chk("t6_rr_route_i", {31'd0, bus.inst_rvalid}, (k % 2 == 0) ? 32'd1 : 32'd0);
      end
`else
      chk("t6_fp_data_gnt", {31'd0, bus.data_gnt}, 32'd1);
      chk("t6_fp_inst_gnt", {31'd0, bus.inst_gnt}, 32'd0);
      if (k > 0) begin
        chk("t6_fp_route_d", {31'd0, bus.data_rvalid}, 32'd1);
      end
`endif
      tick();
    end
    idle(); bus.mem_data_ok = 1'b1;
    #1;
`ifdef ARB_ROUND_ROBIN_EN
    chk("t6_last_inst_rvalid", {31'd0, bus.inst_rvalid}, 32'd1);
`else
    chk("t6_last_data_rvalid", {31'd0, bus.data_rvalid}, 32'd1);
`endif
    tick();
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
